// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues 64-bit word addresses to instruction memory
// and buffers returned instruction pairs in a small FIFO for dual-issue decode.
module fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [63:0]       data_i,
    input  logic              mem_stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              pair_valid_o,
    input  logic              pair_ready_i,
    output logic [31:0]       inst0_o,
    output logic [31:0]       inst1_o,
    output logic [31:0]       pc_o,
    output logic              slot0_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_fetch_pc;
    logic             r_inflight;
    logic [31:2]      r_req_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      r_inst0 [DEPTH];
    logic [31:0]      r_inst1 [DEPTH];
    logic [31:3]      r_pc    [DEPTH];
    logic             r_slot0 [DEPTH];

    logic [CNT_W-1:0] w_used;
    logic             w_issue;
    logic             w_capture;
    logic             w_pop;

    // Credit counts the in-flight response so a capture always has a free slot.
    assign w_used    = r_count + {{PTR_W{1'b0}}, r_inflight};
    assign w_issue   = !redirect_i && !mem_stall_i && (w_used < CNT_W'(DEPTH));
    assign w_capture = r_inflight && !redirect_i;
    assign w_pop     = (r_count != '0) && pair_ready_i && !redirect_i;

    assign addr_o        = r_fetch_pc[ADDR_W+2:3];
    assign pair_valid_o  = (r_count != '0);
    assign inst0_o       = r_inst0[r_rd_ptr];
    assign inst1_o       = r_inst1[r_rd_ptr];
    assign pc_o          = {r_pc[r_rd_ptr], 3'b000};
    assign slot0_valid_o = r_slot0[r_rd_ptr];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_req_pc   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_i) begin
                r_fetch_pc <= redirect_pc_i;
            end else if (w_issue) begin
                r_fetch_pc <= {r_fetch_pc[31:3] + 29'd1, 3'b000};
                r_req_pc   <= r_fetch_pc[31:2];
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head outputs read zero immediately.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                r_inst0[gi] <= '0;
                r_inst1[gi] <= '0;
                r_pc[gi]    <= '0;
                r_slot0[gi] <= 1'b0;
            end else if (w_capture && (r_wr_ptr == PTR_W'(gi))) begin
                r_inst0[gi] <= data_i[31:0];
                r_inst1[gi] <= data_i[63:32];
                r_pc[gi]    <= r_req_pc[31:3];
                r_slot0[gi] <= !r_req_pc[2];
            end
        end
    end

endmodule
